// File: rtl/tick_period_meter.sv
// Tick period meter: measures tick-to-tick distance, classifies it
// against two nominal periods and locks onto a stable class.
module tick_period_meter #(
  parameter int PER_A  = 101,
  parameter int PER_B  = 26,
  parameter int TOL    = 2,
  parameter int LOCK_N = 2
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       clr,
  output logic [7:0] period,
  output logic       period_valid,
  output logic       timeout,
  output logic       locked,
  output logic       mode,
  output logic [7:0] edge_count
);

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    LOCKED     = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_A    = 2'd1,
    CLS_B    = 2'd2
  } cls_e;

  localparam int A_LO = PER_A - TOL;
  localparam int A_HI = PER_A + TOL;
  localparam int B_LO = PER_B - TOL;
  localparam int B_HI = PER_B + TOL;
  localparam logic [7:0] LOCK_W = 8'(LOCK_N);

  state_e     state_q, state_d;
  cls_e       cls_q, cls_d, cls;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] period_q, period_d;
  logic [7:0] ec_q, ec_d;
  logic [7:0] match_q, match_d, match_nx;
  logic       pv_q, pv_d;
  logic       to_q, to_d;
  logic       locked_q, locked_d;
  logic       mode_q, mode_d;
  logic       tick_q;
  logic       rise;
  logic       mode_hit;
  logic [7:0] p_new;
  int         p_int;

  assign rise  = tick_in & ~tick_q;
  assign p_new = cnt_q + 8'd1;
  assign p_int = int'({24'd0, p_new});

  always_comb begin
    cls = CLS_NONE;
    unique case (1'b1)
      (p_int >= A_LO && p_int <= A_HI): cls = CLS_A;
      (p_int >= B_LO && p_int <= B_HI): cls = CLS_B;
      default:                          cls = CLS_NONE;
    endcase
  end

  // Run length of identical, classified periods
  always_comb begin
    match_nx = 8'd1;
    if (cls == CLS_NONE) begin
      match_nx = 8'd0;
    end else if (match_q != 8'd0 && cls == cls_q) begin
      match_nx = (match_q == 8'hFF) ? match_q : match_q + 8'd1;
    end
  end

  assign mode_hit = mode_q ? (cls == CLS_A) : (cls == CLS_B);

  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    ec_d     = ec_q;
    match_d  = match_q;
    locked_d = locked_q;
    mode_d   = mode_q;
    pv_d     = 1'b0;
    to_d     = 1'b0;
    if (rise) ec_d = ec_q + 8'd1;
    if (clr) begin
      state_d  = WAIT_FIRST;
      cnt_d    = 8'd0;
      match_d  = 8'd0;
      cls_d    = CLS_NONE;
      locked_d = 1'b0;
      mode_d   = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_FIRST: begin
          if (rise) begin
            cnt_d   = 8'd0;
            state_d = MEASURE;
          end
        end
        MEASURE, LOCKED: begin
          if (rise && cnt_q == 8'hFF) begin
            to_d     = 1'b1;
            cnt_d    = 8'd0;
            match_d  = 8'd0;
            locked_d = 1'b0;
            state_d  = MEASURE;
          end else if (rise) begin
            period_d = p_new;
            pv_d     = 1'b1;
            cnt_d    = 8'd0;
            match_d  = match_nx;
            cls_d    = cls;
            if (state_q == MEASURE) begin
              if (match_nx >= LOCK_W && cls != CLS_NONE) begin
                state_d  = LOCKED;
                locked_d = 1'b1;
                mode_d   = (cls == CLS_A);
              end
            end else if (!mode_hit) begin
              state_d  = MEASURE;
              locked_d = 1'b0;
            end
          end else if (cnt_q == 8'hFF) begin
            to_d     = 1'b1;
            match_d  = 8'd0;
            locked_d = 1'b0;
            state_d  = WAIT_FIRST;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = WAIT_FIRST;
      endcase
    end
  end

  always_ff @(posedge clkin) begin
    if (!reset) begin
      state_q  <= WAIT_FIRST;
      cls_q    <= CLS_NONE;
      cnt_q    <= 8'd0;
      period_q <= 8'd0;
      ec_q     <= 8'd0;
      match_q  <= 8'd0;
      pv_q     <= 1'b0;
      to_q     <= 1'b0;
      locked_q <= 1'b0;
      mode_q   <= 1'b0;
      tick_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      ec_q     <= ec_d;
      match_q  <= match_d;
      pv_q     <= pv_d;
      to_q     <= to_d;
      locked_q <= locked_d;
      mode_q   <= mode_d;
      tick_q   <= tick_in;
    end
  end

  assign period       = period_q;
  assign period_valid = pv_q;
  assign timeout      = to_q;
  assign locked       = locked_q;
  assign mode         = mode_q;
  assign edge_count   = ec_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: directed scenarios plus random tick
// streams compared against a timestamp-based reference model.
module tb_tick_period_meter;

  localparam int PA = 101;
  localparam int PB = 26;
  localparam int TL = 2;
  localparam int LN = 2;

  logic       clkin = 1'b0;
  logic       reset = 1'b0;
  logic       tick_in = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] period;
  logic [7:0] edge_count;
  logic       period_valid;
  logic       timeout;
  logic       locked;
  logic       mode;

  tick_period_meter #(
    .PER_A (PA),
    .PER_B (PB),
    .TOL   (TL),
    .LOCK_N(LN)
  ) dut (
    .clkin       (clkin),
    .reset       (reset),
    .tick_in     (tick_in),
    .clr         (clr),
    .period      (period),
    .period_valid(period_valid),
    .timeout     (timeout),
    .locked      (locked),
    .mode        (mode),
    .edge_count  (edge_count)
  );

  always #5 clkin = ~clkin;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  bit m_prev = 1'b1;
  bit m_arm = 1'b0;
  int m_last = 0;
  int m_period = 0;
  bit m_pv = 1'b0;
  bit m_to = 1'b0;
  bit m_locked = 1'b0;
  bit m_mode = 1'b0;
  int m_ec = 0;
  int hist[$];

  int pv_cnt = 0;
  int to_cyc = -1;
  bit lock_at_pv = 1'b0;
  bit saw_lock_a = 1'b0;
  bit saw_lock_b = 1'b0;

  task automatic chk(string tag, logic [31:0] got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int cls_of(int p);
    if (p >= PA - TL && p <= PA + TL) return 1;
    if (p >= PB - TL && p <= PB + TL) return 2;
    return 0;
  endfunction

  // Length of the trailing run of one identical, classified period
  function automatic int run_len();
    int n = 0;
    int c;
    if (hist.size() == 0) return 0;
    c = hist[hist.size()-1];
    if (c == 0) return 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != c) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_step(bit t, bit c, bit r);
    bit rise;
    int age;
    int k;
    m_pv = 1'b0;
    m_to = 1'b0;
    if (!r) begin
      m_prev = 1'b1;
      m_arm = 1'b0;
      hist.delete();
      m_period = 0;
      m_locked = 1'b0;
      m_mode = 1'b0;
      m_ec = 0;
      return;
    end
    rise = t && !m_prev;
    m_prev = t;
    if (rise) m_ec = (m_ec + 1) % 256;
    if (c) begin
      m_arm = 1'b0;
      hist.delete();
      m_locked = 1'b0;
      m_mode = 1'b0;
      return;
    end
    if (!m_arm) begin
      if (rise) begin
        m_arm = 1'b1;
        m_last = cyc;
      end
      return;
    end
    age = cyc - m_last;
    if (rise && age == 256) begin
      m_to = 1'b1;
      hist.delete();
      m_locked = 1'b0;
      m_last = cyc;
    end else if (rise) begin
      m_period = age;
      m_pv = 1'b1;
      k = cls_of(age);
      hist.push_back(k);
      if (hist.size() > 512) void'(hist.pop_front());
      if (run_len() >= LN) begin
        m_locked = 1'b1;
        m_mode = (k == 1);
      end else begin
        m_locked = 1'b0;
      end
      m_last = cyc;
    end else if (age == 256) begin
      m_to = 1'b1;
      m_arm = 1'b0;
      hist.delete();
      m_locked = 1'b0;
    end
  endtask

  task automatic step(bit t, bit c = 1'b0, bit r = 1'b1);
    tick_in = t;
    clr = c;
    reset = r;
    @(posedge clkin);
    cyc++;
    model_step(t, c, r);
    @(negedge clkin);
    chk("period_valid", period_valid, m_pv);
    chk("timeout", timeout, m_to);
    chk("locked", locked, m_locked);
    chk("edge_count", edge_count, m_ec);
    chk("period", period, m_period);
    if (m_locked) chk("mode", mode, m_mode);
    if (period_valid === 1'b1) begin
      pv_cnt++;
      lock_at_pv = locked;
      if (locked && mode) saw_lock_a = 1'b1;
      if (locked && !mode) saw_lock_b = 1'b1;
    end
    if (timeout === 1'b1 && to_cyc < 0) to_cyc = cyc;
  endtask

  task automatic pulse(int gap, int w = 1);
    for (int i = 0; i < gap; i++) step(i < w);
  endtask

  task automatic do_reset(bit t = 1'b0);
    for (int i = 0; i < 3; i++) step(t, 1'b0, 1'b0);
    pv_cnt = 0;
    to_cyc = -1;
    lock_at_pv = 1'b0;
    saw_lock_a = 1'b0;
    saw_lock_b = 1'b0;
  endtask

  initial begin
    int e;
    int sel;
    int gap;
    int w;

    do_reset();
    chk("rst_period", period, 0);
    chk("rst_ec", edge_count, 0);
    chk("rst_locked", locked, 0);
    chk("rst_mode", mode, 0);
    repeat (4) step(1'b0);

    pulse(101);
    pulse(101);
    pulse(50);
    chk("a_ec", edge_count, 3);
    chk("a_period", period, 101);
    chk("a_pvcnt", pv_cnt, 2);
    chk("a_lock_at_pv", lock_at_pv, 1);
    chk("a_mode", mode, 1);

    do_reset();
    repeat (2) step(1'b0);
    repeat (3) pulse(26);
    pulse(101);
    pulse(20);
    chk("b_saw_lock", saw_lock_b, 1);
    chk("b_locked", locked, 0);
    chk("b_period", period, 101);
    chk("b_pvcnt", pv_cnt, 4);

    do_reset();
    repeat (2) step(1'b0);
    pulse(99);
    pulse(103);
    pulse(104);
    pulse(20);
    chk("c_saw_lock", saw_lock_a, 1);
    chk("c_locked", locked, 0);
    chk("c_period", period, 104);

    do_reset();
    repeat (2) step(1'b0);
    pulse(1);
    e = cyc;
    repeat (300) step(1'b0);
    chk("d_to_dist", to_cyc - e, 256);
    chk("d_pvcnt", pv_cnt, 0);
    to_cyc = -1;
    pulse(256);
    e = cyc - 255;
    pulse(40);
    chk("e_to_dist", to_cyc - e, 256);
    chk("e_pvcnt", pv_cnt, 0);
    pulse(20);
    chk("e_period", period, 40);
    chk("e_pvcnt2", pv_cnt, 1);

    do_reset(1'b1);
    repeat (5) step(1'b1);
    chk("f_ec_held", edge_count, 0);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    chk("f_ec_rise", edge_count, 1);

    do_reset();
    step(1'b0);
    repeat (256) pulse(3);
    chk("g_ec_wrap", edge_count, 0);
    chk("g_period", period, 3);
    chk("g_pvcnt", pv_cnt, 255);

    do_reset();
    step(1'b0);
    pulse(50);
    do_reset();
    step(1'b0);
    pulse(30);
    pulse(10);
    chk("h_period", period, 30);
    chk("h_pvcnt", pv_cnt, 1);

    repeat (60) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: gap = $urandom_range(PB - 4, PB + 4);
        1: gap = $urandom_range(PA - 4, PA + 4);
        2: gap = $urandom_range(2, 300);
        default: gap = $urandom_range(250, 260);
      endcase
      w = $urandom_range(1, gap - 1);
      for (int i = 0; i < gap; i++) begin
        step(i < w, $urandom_range(0, 99) == 0,
             $urandom_range(0, 399) != 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_period_meter.md
TICK_PERIOD_METER -- requirements
Module: tick_period_meter

Interface
REQ-001 SHALL have parameter PER_A, default 101, meaning nominal tick period in clocks for class A.
REQ-002 SHALL have parameter PER_B, default 26, meaning nominal tick period in clocks for class B.
REQ-003 SHALL have parameter TOL, default 2, meaning allowed +/- deviation in clocks for a class match.
REQ-004 SHALL have parameter LOCK_N, default 2, meaning consecutive same-class periods required to lock.
REQ-005 SHALL have port clkin, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning synchronous active-low reset.
REQ-007 SHALL have port tick_in, input, 1, meaning clkin-synchronous tick stream; a rising edge marks a tick.
REQ-008 SHALL have port clr, input, 1, meaning synchronous active-high measurement restart.
REQ-009 SHALL have port period, output, 8, meaning the last measured tick-to-tick distance in clocks.
REQ-010 SHALL have port period_valid, output, 1, meaning a one-cycle pulse when period updates.
REQ-011 SHALL have port timeout, output, 1, meaning a one-cycle pulse when no tick arrives within 255 clocks.
REQ-012 SHALL have port locked, output, 1, meaning the tick stream is stable in one class.
REQ-013 SHALL have port mode, output, 1, meaning the locked class (1 = A, 0 = B), valid only while locked.
REQ-014 SHALL have port edge_count, output, 8, meaning the wrapping count of detected ticks.

Function
REQ-015 SHALL register tick_in into tick_q each cycle; rise = tick_in AND NOT tick_q.
REQ-016 SHALL implement states WAIT_FIRST, MEASURE and LOCKED.
REQ-017 SHALL, in WAIT_FIRST on rise, clear cnt to 0 and go to MEASURE, with no period_valid.
REQ-018 SHALL, in MEASURE or LOCKED, increment the 8-bit cnt each cycle without rise, saturating at 255.
REQ-019 SHALL, on rise with cnt < 255, load period <= cnt+1, pulse period_valid in the next cycle, and clear cnt to 0.
REQ-020 SHALL treat edges at cycles t0 and t0+P as yielding period = P; the measurable range is 1..255.
REQ-021 SHALL classify a period as A if PER_A-TOL <= P <= PER_A+TOL, B if PER_B-TOL <= P <= PER_B+TOL, and otherwise as none.
REQ-022 SHALL keep a consecutive-match counter that increments when the class equals the previous class, resets to 1 on a class change, and resets to 0 on class none.
REQ-023 SHALL enter LOCKED and set locked=1 and mode=class in the same cycle that period_valid reports the LOCK_N-th consecutive match.
REQ-024 SHALL, in LOCKED, drop to MEASURE with locked=0 in the period_valid cycle of any period whose class differs from mode.
REQ-025 SHALL, when cnt==255 without rise, pulse timeout, go to WAIT_FIRST, and clear locked and the match counter.
REQ-026 SHALL, on rise coinciding with cnt==255, pulse timeout, suppress period_valid, clear the match counter and locked, clear cnt, and stay in MEASURE.
REQ-027 SHALL increment edge_count on every rise in every state, wrapping from 255 to 0.
REQ-028 SHALL, on clr=1, behave as reset for state, cnt, locked, mode and the match counter, and SHALL NOT alter edge_count, period or tick_q.
REQ-029 SHALL give reset priority over clr, and clr priority over rise.

Reset
REQ-030 SHALL, while reset=0 at a clkin edge, set state=WAIT_FIRST, cnt=0, period=0, period_valid=0, timeout=0, locked=0, mode=0, edge_count=0, match counter=0, and tick_q=1.
REQ-031 SHALL, because tick_q resets to 1, not count a tick_in held high across reset release as an edge.
REQ-032 SHALL abandon any in-progress measurement when reset is applied mid-period.

Verification
REQ-033 SHALL cover: ticks every 101 clocks, 3 edges -> period=101 twice, locked=1 and mode=1 at the second period_valid, edge_count=3.
REQ-034 SHALL cover: ticks every 26 clocks, then one interval of 101 -> lock with mode=0, then locked=0 at the 101 period_valid.
REQ-035 SHALL cover: intervals of 99, 103 and 104 clocks -> two A matches lock; 104 is class none and drops the lock.
REQ-036 SHALL cover: one tick, then silence -> timeout pulse at 256 clocks after the edge, state WAIT_FIRST, no period_valid.
REQ-037 SHALL cover: tick_in high while reset releases -> edge_count stays 0 until tick_in falls and rises again.
REQ-038 SHALL cover: 256 single-cycle ticks every 3 clocks -> edge_count wraps to 0 and period=3 throughout.
